// File: rtl/shift_sequencer_pkg.sv
// Shared encodings and default widths for the multi-cycle shift sequencer.
package shift_sequencer_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_AMT_W = 4;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_RSV = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational one-bit shift stage; the reserved mode passes data through unchanged.
module shift_step
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] din,
    input  mode_t            mode,
    output logic [WIDTH-1:0] dout,
    output logic             shifted_bit
);

    always_comb begin
        dout        = din;
        shifted_bit = 1'b0;
        case (mode)
            MODE_SLL: begin
                dout        = {din[WIDTH-2:0], 1'b0};
                shifted_bit = din[WIDTH-1];
            end
            MODE_SRL: begin
                dout        = {1'b0, din[WIDTH-1:1]};
                shifted_bit = din[0];
            end
            MODE_SRA: begin
                dout        = {din[WIDTH-1], din[WIDTH-1:1]};
                shifted_bit = din[0];
            end
            default: begin
                dout        = din;
                shifted_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: iterates shift_step one bit per clock under a start/busy/done handshake.
//   state    | meaning
//   ST_IDLE  | waiting for start; result/carry_out hold the last answer
//   ST_SHIFT | one shift step per clock, count tracks steps remaining
//   ST_DONE  | one-cycle done pulse, result valid
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = DEF_AMT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_data,
    input  logic [AMT_W-1:0] op_amt,
    input  logic [1:0]       op_mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    state_t           state;
    mode_t            mode;
    logic [AMT_W-1:0] count;
    logic [WIDTH-1:0] step_out;
    logic             step_bit;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .din         (result),
        .mode        (mode),
        .dout        (step_out),
        .shifted_bit (step_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            mode      <= MODE_SLL;
            count     <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        result    <= op_data;
                        count     <= op_amt;
                        mode      <= mode_t'(op_mode);
                        carry_out <= 1'b0;
                        busy      <= 1'b1;
                        // Zero-amount and reserved-mode requests skip straight to the done pulse.
                        if (op_amt == '0 || op_mode == MODE_RSV) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    result    <= step_out;
                    carry_out <= step_bit;
                    count     <= count - AMT_W'(1);
                    if (count == AMT_W'(1)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: driver queues expected results, a monitor checks each done pulse.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] op_data;
    logic [3:0]  op_amt;
    logic [1:0]  op_mode;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry_out;

    typedef struct {
        logic [15:0] res;
        logic        c;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   t0;

    shift_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op_data   (op_data),
        .op_amt    (op_amt),
        .op_mode   (op_mode),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; start is high for exactly one cycle.
    task automatic issue(input logic [15:0] d, input logic [3:0] a, input logic [1:0] m,
                         input logic [15:0] er, input logic ec, input int lat, input bit expect_done);
        exp_t e;
        start   = 1'b1;
        op_data = d;
        op_amt  = a;
        op_mode = m;
        t0      = cyc;
        if (expect_done) begin
            e.res = er;
            e.c   = ec;
            e.cyc = cyc + lat;
            sb.push_back(e);
        end
        step();
        start   = 1'b0;
        op_data = 16'hDEAD;
        op_amt  = 4'hF;
        op_mode = 2'b01;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_timeout", 32'(n >= 200), 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("carry_out", 32'(carry_out), 32'(e.c));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("busy_at_done", 32'(busy), 32'd1);
            end
        end
    end

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        op_data = '0;
        op_amt  = '0;
        op_mode = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_carry", 32'(carry_out), 32'd0);
        step();
        reset = 1'b0;
        step();

        // SLL 1 by 4: busy over T+1..T+5, done at T+5
        issue(16'h0001, 4'd4, 2'b00, 16'h0010, 1'b0, 5, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("sll4_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        chk("sll4_busy_after", 32'(busy), 32'd0);
        wait_idle();

        step();
        issue(16'h8001, 4'd1, 2'b01, 16'h4000, 1'b1, 2, 1'b1);
        wait_idle();
        step();
        issue(16'h8000, 4'd15, 2'b10, 16'hFFFF, 1'b0, 16, 1'b1);
        wait_idle();
        step();
        issue(16'hA5A5, 4'd0, 2'b00, 16'hA5A5, 1'b0, 1, 1'b1);
        wait_idle();
        step();
        issue(16'h1234, 4'd7, 2'b11, 16'h1234, 1'b0, 1, 1'b1);
        wait_idle();

        // Starts during SHIFT and DONE are ignored
        step();
        issue(16'h00FF, 4'd8, 2'b00, 16'hFF00, 1'b0, 9, 1'b1);
        repeat (2) step();
        start = 1'b1; op_data = 16'h0F0F; op_amt = 4'd3; op_mode = 2'b01;
        step();
        start = 1'b0;
        repeat (5) step();
        start = 1'b1; op_data = 16'h1111; op_amt = 4'd2; op_mode = 2'b10;
        step();
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("ignored_start_result_hold", 32'(result), 32'h0000FF00);
        wait_idle();

        // Reset mid-shift aborts without a done pulse
        step();
        issue(16'hF000, 4'd10, 2'b10, 16'h0000, 1'b0, 0, 1'b0);
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_carry", 32'(carry_out), 32'd0);
        repeat (12) @(negedge clk);
        step();
        issue(16'h0003, 4'd2, 2'b00, 16'h000C, 1'b0, 3, 1'b1);
        wait_idle();

        // Back-to-back: second start in the first IDLE cycle after DONE
        step();
        issue(16'h0001, 4'd15, 2'b00, 16'h8000, 1'b0, 16, 1'b1);
        begin
            int n = 0;
            @(negedge clk);
            while (!done && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_first_done_timeout", 32'(n >= 40), 32'd0);
        end
        step();
        issue(16'h8000, 4'd1, 2'b00, 16'h0000, 1'b1, 2, 1'b1);
        wait_idle();
        repeat (4) @(negedge clk);
        chk("hold_result", 32'(result), 32'h0);
        chk("hold_carry", 32'(carry_out), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
